// File: rtl/muldiv_unit_pkg.sv
// muldiv_unit_pkg: SPECIAL funct codes shared by decoder, ALU and the muldiv unit,
// plus the decode of a funct into the operation classes the muldiv unit handles.
package muldiv_unit_pkg;
  localparam logic [5:0] FN_MTHI  = 6'h11;
  localparam logic [5:0] FN_MTLO  = 6'h13;
  localparam logic [5:0] FN_MULT  = 6'h18;
  localparam logic [5:0] FN_MULTU = 6'h19;
  localparam logic [5:0] FN_DIV   = 6'h1A;
  localparam logic [5:0] FN_DIVU  = 6'h1B;
  typedef struct packed {
    logic valid;
    logic mul;
    logic div;
    logic sgn;
    logic mthi;
    logic mtlo;
  } op_t;
  function automatic op_t decode_op(input logic [5:0] fn);
    op_t o;
    o.mul   = fn == FN_MULT || fn == FN_MULTU;
    o.div   = fn == FN_DIV || fn == FN_DIVU;
    o.sgn   = fn == FN_MULT || fn == FN_DIV;
    o.mthi  = fn == FN_MTHI;
    o.mtlo  = fn == FN_MTLO;
    o.valid = o.mul | o.div | o.mthi | o.mtlo;
    return o;
  endfunction
endpackage

// File: rtl/muldiv_unit_div_step.sv
// muldiv_div_step: one restoring-divide step; shifts the next dividend bit into the
// partial remainder and subtracts the divisor when it fits.
module muldiv_div_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] rem_i,
  input  logic [WIDTH-1:0] divisor_i,
  input  logic             bit_i,
  output logic [WIDTH-1:0] rem_o,
  output logic             q_o
);
  logic [WIDTH:0] trial;
  always_comb begin
    trial = {rem_i, bit_i};
    q_o   = trial >= {1'b0, divisor_i};
    rem_o = q_o ? WIDTH'(trial - {1'b0, divisor_i}) : trial[WIDTH-1:0];
  end
endmodule

// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative multiply/divide owning HI/LO; one result bit per cycle on
// operand magnitudes, signs applied when the final iteration writes HI/LO.
module muldiv_unit
  import muldiv_unit_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             w_clk,
  input  logic             w_reset_n,
  input  logic             w_start,
  input  logic [5:0]       w_op_code_6,
  input  logic [WIDTH-1:0] w_rs_x,
  input  logic [WIDTH-1:0] w_rt_x,
  output logic             w_busy,
  output logic             w_done,
  output logic [WIDTH-1:0] w_hi_x,
  output logic [WIDTH-1:0] w_lo_x
);
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] MUL  = 2'd1;
  localparam logic [1:0] DIV  = 2'd2;
  localparam int CW = $clog2(WIDTH) + 1;

  logic [1:0]         state_q, state_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [WIDTH-1:0]   hi_q, hi_d, lo_q, lo_d;
  logic [WIDTH-1:0]   r_q, r_d, x_q, x_d, m_q, m_d;
  logic               neg_q, neg_d, rneg_q, rneg_d, done_q, done_d;
  op_t                op;
  logic               accept, last, rs_neg, rt_neg, q_bit;
  logic [WIDTH-1:0]   rs_mag, rt_mag, rem_next, q_next;
  logic [WIDTH:0]     sum;
  logic [2*WIDTH-1:0] prod;

  assign op     = decode_op(w_op_code_6);
  assign accept = w_start && state_q == IDLE && op.valid;
  assign rs_neg = op.sgn & w_rs_x[WIDTH-1];
  assign rt_neg = op.sgn & w_rt_x[WIDTH-1];
  assign rs_mag = rs_neg ? -w_rs_x : w_rs_x;
  assign rt_mag = rt_neg ? -w_rt_x : w_rt_x;

  // r holds product high word / partial remainder, x the multiplier / dividend-quotient
  assign sum    = {1'b0, r_q} + (x_q[0] ? {1'b0, m_q} : '0);
  assign prod   = {sum, x_q[WIDTH-1:1]};
  assign q_next = {x_q[WIDTH-2:0], q_bit};

  muldiv_div_step #(.WIDTH(WIDTH)) u_step (
    .rem_i     (r_q),
    .divisor_i (m_q),
    .bit_i     (x_q[WIDTH-1]),
    .rem_o     (rem_next),
    .q_o       (q_bit)
  );

  always_ff @(posedge w_clk or negedge w_reset_n)
    if (!w_reset_n) state_q <= IDLE;
    else state_q <= state_d;

  always_comb begin
    state_d = state_q;
    if (accept) state_d = op.mul ? MUL : op.div ? DIV : IDLE;
    else if (last) state_d = IDLE;
  end

  always_comb begin
    w_busy = state_q != IDLE;
    last   = w_busy && cnt_q == CW'(1);
    w_done = done_q;
    w_hi_x = hi_q;
    w_lo_x = lo_q;
  end

  always_comb begin
    cnt_d  = cnt_q;
    r_d    = r_q;
    x_d    = x_q;
    m_d    = m_q;
    neg_d  = neg_q;
    rneg_d = rneg_q;
    hi_d   = hi_q;
    lo_d   = lo_q;
    done_d = 1'b0;
    if (accept) begin
      hi_d   = op.mthi ? w_rs_x : hi_q;
      lo_d   = op.mtlo ? w_rs_x : lo_q;
      done_d = op.mthi | op.mtlo;
      cnt_d  = (op.mul | op.div) ? CW'(WIDTH) : cnt_q;
      r_d    = '0;
      x_d    = op.mul ? rt_mag : rs_mag;
      m_d    = op.mul ? rs_mag : rt_mag;
      // a zero divisor keeps the all-ones quotient unsigned and HI equal to rs
      neg_d  = (rs_neg ^ rt_neg) & ~(op.div & ~|w_rt_x);
      rneg_d = rs_neg;
    end else if (w_busy) begin
      cnt_d = cnt_q - CW'(1);
      r_d   = state_q == MUL ? sum[WIDTH:1] : rem_next;
      x_d   = state_q == MUL ? prod[WIDTH-1:0] : q_next;
      if (last) begin
        hi_d   = state_q == MUL ? (neg_q ? -prod : prod) >> WIDTH : {WIDTH{1'b0}} | (rneg_q ? -rem_next : rem_next);
        lo_d   = state_q == MUL ? WIDTH'(neg_q ? -prod : prod) : (neg_q ? -q_next : q_next);
        done_d = 1'b1;
      end
    end
  end

  always_ff @(posedge w_clk or negedge w_reset_n)
    if (!w_reset_n) begin
      cnt_q  <= '0;
      r_q    <= '0;
      x_q    <= '0;
      m_q    <= '0;
      neg_q  <= 1'b0;
      rneg_q <= 1'b0;
      hi_q   <= '0;
      lo_q   <= '0;
      done_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      r_q    <= r_d;
      x_q    <= x_d;
      m_q    <= m_d;
      neg_q  <= neg_d;
      rneg_q <= rneg_d;
      hi_q   <= hi_d;
      lo_q   <= lo_d;
      done_q <= done_d;
    end
endmodule

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit: directed vector table for MULT/DIV/MT* results and latency, plus
// hand sequences for invalid opcodes, start-while-busy, back-to-back issue and mid-op reset.
module tb_muldiv_unit;
  typedef struct {
    logic [5:0]  op;
    logic [31:0] rs, rt, hi, lo;
    int          lat;
  } vec_t;

  logic        w_clk = 1'b0, w_reset_n = 1'b0, w_start = 1'b0;
  logic [5:0]  w_op_code_6 = '0;
  logic [31:0] w_rs_x = '0, w_rt_x = '0;
  logic        w_busy, w_done;
  logic [31:0] w_hi_x, w_lo_x;
  int          checks = 0, errors = 0;
  vec_t        v[15];

  always #5 w_clk = ~w_clk;

  muldiv_unit #(.WIDTH(32)) dut (
    .w_clk(w_clk), .w_reset_n(w_reset_n), .w_start(w_start), .w_op_code_6(w_op_code_6),
    .w_rs_x(w_rs_x), .w_rt_x(w_rt_x), .w_busy(w_busy), .w_done(w_done),
    .w_hi_x(w_hi_x), .w_lo_x(w_lo_x)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic wait_done(output int n, output int busy_n);
    n = 0;
    busy_n = 0;
    while (!w_done && n < 100) begin
      if (w_busy) busy_n++;
      @(negedge w_clk);
      n++;
    end
  endtask

  task automatic run_op(input string nm, input logic [5:0] op, input logic [31:0] rs, input logic [31:0] rt,
                        input logic [31:0] hi, input logic [31:0] lo, input int lat);
    int n, busy_n;
    @(negedge w_clk);
    w_start = 1'b1; w_op_code_6 = op; w_rs_x = rs; w_rt_x = rt;
    @(negedge w_clk);
    w_start = 1'b0; w_op_code_6 = 6'h1B; w_rs_x = 32'h5A5A5A5A; w_rt_x = 32'hA5A5A5A5;
    wait_done(n, busy_n);
    chk({nm, "_done"}, 32'(w_done), 32'd1);
    chk({nm, "_latency"}, 32'(n), 32'(lat));
    chk({nm, "_busy_cycles"}, 32'(busy_n), 32'(lat));
    chk({nm, "_hi"}, w_hi_x, hi);
    chk({nm, "_lo"}, w_lo_x, lo);
    @(negedge w_clk);
    chk({nm, "_done_pulse"}, 32'(w_done), 32'd0);
  endtask

  initial begin
    int n, busy_n, dones, bad;
    v[0]  = '{6'h19, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 32};
    v[1]  = '{6'h18, 32'hFFFFFFFD, 32'h00000005, 32'hFFFFFFFF, 32'hFFFFFFF1, 32};
    v[2]  = '{6'h1B, 32'h00000007, 32'h00000002, 32'h00000001, 32'h00000003, 32};
    v[3]  = '{6'h1A, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD, 32};
    v[4]  = '{6'h1A, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 32};
    v[5]  = '{6'h1B, 32'h00001234, 32'h00000000, 32'h00001234, 32'hFFFFFFFF, 32};
    v[6]  = '{6'h18, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, 32};
    v[7]  = '{6'h19, 32'h12345678, 32'h00000010, 32'h00000001, 32'h23456780, 32};
    v[8]  = '{6'h18, 32'h00000007, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFF9, 32};
    v[9]  = '{6'h1A, 32'h00000007, 32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD, 32};
    v[10] = '{6'h1B, 32'hFFFFFFFF, 32'h00000010, 32'h0000000F, 32'h0FFFFFFF, 32};
    v[11] = '{6'h1A, 32'hFFFFFFF9, 32'h00000000, 32'hFFFFFFF9, 32'hFFFFFFFF, 32};
    v[12] = '{6'h18, 32'h00000000, 32'h80000000, 32'h00000000, 32'h00000000, 32};
    v[13] = '{6'h11, 32'hDEADBEEF, 32'h00000000, 32'hDEADBEEF, 32'h00000000, 0};
    v[14] = '{6'h13, 32'hCAFEF00D, 32'h00000000, 32'hDEADBEEF, 32'hCAFEF00D, 0};

    repeat (3) @(negedge w_clk);
    chk("reset_busy", 32'(w_busy), 32'd0);
    chk("reset_done", 32'(w_done), 32'd0);
    chk("reset_hi", w_hi_x, 32'd0);
    chk("reset_lo", w_lo_x, 32'd0);
    w_reset_n = 1'b1;

    for (int i = 0; i < 15; i++)
      run_op($sformatf("vec%0d", i), v[i].op, v[i].rs, v[i].rt, v[i].hi, v[i].lo, v[i].lat);

    // unsupported funct must be ignored entirely
    @(negedge w_clk);
    w_start = 1'b1; w_op_code_6 = 6'h20; w_rs_x = 32'h11111111; w_rt_x = 32'h2;
    @(negedge w_clk);
    w_start = 1'b0;
    bad = 0;
    for (int i = 0; i < 5; i++) begin
      if (w_done || w_busy) bad++;
      @(negedge w_clk);
    end
    chk("invalid_no_activity", 32'(bad), 32'd0);
    chk("invalid_hi", w_hi_x, 32'hDEADBEEF);
    chk("invalid_lo", w_lo_x, 32'hCAFEF00D);

    // start while busy is dropped
    @(negedge w_clk);
    w_start = 1'b1; w_op_code_6 = 6'h19; w_rs_x = 32'd2; w_rt_x = 32'd3;
    @(negedge w_clk);
    w_start = 1'b0;
    @(negedge w_clk);
    w_start = 1'b1; w_op_code_6 = 6'h11; w_rs_x = 32'h11111111;
    @(negedge w_clk);
    w_start = 1'b0;
    dones = 0; bad = 0;
    for (int i = 0; i < 40; i++) begin
      if (w_done) dones++;
      if (w_busy && (w_hi_x !== 32'hDEADBEEF || w_lo_x !== 32'hCAFEF00D)) bad++;
      @(negedge w_clk);
    end
    chk("busy_start_one_done", 32'(dones), 32'd1);
    chk("busy_hilo_hold", 32'(bad), 32'd0);
    chk("busy_start_hi", w_hi_x, 32'd0);
    chk("busy_start_lo", w_lo_x, 32'd6);

    // back-to-back: new start accepted on the edge that clears done
    @(negedge w_clk);
    w_start = 1'b1; w_op_code_6 = 6'h19; w_rs_x = 32'd5; w_rt_x = 32'd5;
    @(negedge w_clk);
    w_start = 1'b0;
    wait_done(n, busy_n);
    chk("b2b_first_done", 32'(w_done), 32'd1);
    chk("b2b_first_lo", w_lo_x, 32'd25);
    w_start = 1'b1; w_op_code_6 = 6'h13; w_rs_x = 32'd77;
    @(negedge w_clk);
    w_start = 1'b0;
    chk("b2b_second_done", 32'(w_done), 32'd1);
    chk("b2b_second_lo", w_lo_x, 32'd77);
    chk("b2b_second_hi", w_hi_x, 32'd0);

    run_op("mthi_pre_reset", 6'h11, 32'hA5A5A5A5, 32'd0, 32'hA5A5A5A5, 32'd77, 0);

    // asynchronous reset at iteration 10 of a divide
    @(negedge w_clk);
    w_start = 1'b1; w_op_code_6 = 6'h1B; w_rs_x = 32'hFFFFFFFF; w_rt_x = 32'd3;
    @(negedge w_clk);
    w_start = 1'b0;
    repeat (10) @(negedge w_clk);
    chk("midreset_busy_before", 32'(w_busy), 32'd1);
    #2 w_reset_n = 1'b0;
    #1;
    chk("midreset_busy", 32'(w_busy), 32'd0);
    chk("midreset_done", 32'(w_done), 32'd0);
    chk("midreset_hi", w_hi_x, 32'd0);
    chk("midreset_lo", w_lo_x, 32'd0);
    @(negedge w_clk);
    w_reset_n = 1'b1;
    run_op("post_reset_multu", 6'h19, 32'd2, 32'd3, 32'd0, 32'd6, 32);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
